// File: rtl/serial_sub8.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with a start handshake on the operands and a valid/ack handshake on the result.
//
// state | meaning
// IDLE  | waiting for start; last result held on diff/borrow/zero
// RUN   | one difference bit produced per edge, WIDTH edges total
// DONE  | result valid, held until ack
module serial_sub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             valid,
    input  logic             ack,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [CW-1:0]    cnt_q;
    logic             br_q;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] r_next;
    logic             last_bit;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    if (ack)      state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSBs
    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ br_q;
        br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br_q);
        r_next   = {d_bit, r_sh[WIDTH-1:1]};
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            cnt_q  <= '0;
            br_q   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        br_q  <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    br_q  <= br_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        diff   <= r_next;
                        borrow <= br_next;
                        zero   <= (r_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign valid = (state_q == DONE);

endmodule

// File: tb/tb_serial_sub8.sv
// Randomized self-checking bench for serial_sub8 against an arithmetic reference
// (9-bit subtraction gives both the difference and the borrow).
module tb_serial_sub8;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             ack = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             busy, valid, borrow, zero;
    logic [WIDTH-1:0] diff;

    int n_checks = 0;
    int n_fail   = 0;

    serial_sub8 #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .valid  (valid),
        .ack    (ack),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: start, wait for valid, hold, ack.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                         input bit inject, input logic [7:0] ia, input logic [7:0] ib,
                         input bit ack_start);
        logic [8:0] t;
        logic [7:0] exp_diff;
        int k;
        t        = {1'b0, a} - {1'b0, b};
        exp_diff = t[7:0];

        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        check("busy_after_start", busy, 1);

        k = 0;
        while (!valid && k < 20) begin
            @(negedge clk);
            k++;
            if (inject && k == 3) begin
                start = 1'b1;
                ack   = 1'b1;
                a_in  = ia;
                b_in  = ib;
            end else if (inject && k == 4) begin
                start = 1'b0;
                ack   = 1'b0;
            end
        end
        start = 1'b0;
        ack   = 1'b0;
        check("latency", k, WIDTH);
        check("valid", valid, 1);
        check("diff", diff, exp_diff);
        check("borrow", borrow, t[8]);
        check("zero", zero, (exp_diff == 8'h00));

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", valid, 1);
            check("hold_diff", diff, exp_diff);
        end

        ack   = 1'b1;
        start = ack_start;
        @(negedge clk);
        ack   = 1'b0;
        start = 1'b0;
        check("valid_after_ack", valid, 0);
        check("busy_after_ack", busy, 0);
        check("diff_retained", diff, exp_diff);
        check("borrow_retained", borrow, t[8]);
        if (ack_start) begin
            @(negedge clk);
            check("no_restart", busy, 0);
        end
    endtask

    initial begin
        int seen_valid;

        // Reset with start/ack held high
        @(negedge clk);
        rst = 1'b1; start = 1'b1; ack = 1'b1;
        a_in = 8'h12; b_in = 8'h34;
        repeat (2) @(negedge clk);
        rst = 1'b0; start = 1'b0; ack = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_zero", zero, 0);
        @(negedge clk);
        check("rst_no_start", busy, 0);

        // Directed cases
        do_op(8'h5A, 8'h23, 0, 1'b0, 8'h00, 8'h00, 1'b0);
        do_op(8'h00, 8'h01, 0, 1'b0, 8'h00, 8'h00, 1'b0);
        do_op(8'h80, 8'h80, 0, 1'b0, 8'h00, 8'h00, 1'b0);
        do_op(8'hC8, 8'h13, 0, 1'b1, 8'h01, 8'h02, 1'b0);
        do_op(8'h3C, 8'h7E, 5, 1'b0, 8'h00, 8'h00, 1'b1);
        do_op(8'hA5, 8'h5A, 1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Reset sampled at RUN edge 4 aborts the operation
        @(negedge clk);
        a_in = 8'h10; b_in = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        check("abort_zero", zero, 0);
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid) seen_valid++;
        end
        check("abort_no_valid", seen_valid, 0);
        do_op(8'hFF, 8'hFF, 0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Random operands, hold times and mid-run noise on start/ack
        for (int n = 0; n < 40; n++) begin
            do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
                  bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
